des_round_sequencer: RTL and testbench

Sequencer that drives the subkey generator's control inputs and the Feistel datapath for one triple-DES (EDE) block. On an accepted `start` it runs three passes of one key-load cycle plus 16 rounds each. It produces `round_count`, `key_count`, `cnt_rollover`, `key_rollover` and `reverse` for the key generator, plus `load_block`, `round_en` and `done` for the datapath. It sits between the USB-side block handshake and the encryption core.

---
 rtl/des_round_sequencer.sv | 107 ++++++++++
 tb/tb_des_round_sequencer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/des_round_sequencer.sv
// Control sequencer for one triple-DES (EDE) block: three passes of a key-load
// cycle plus NUM_ROUNDS rounds, driving the subkey generator and Feistel datapath.
module des_round_sequencer #(
   parameter int NUM_ROUNDS = 16,
   parameter int NUM_PASSES = 3
) (
   input  logic       clk,
   input  logic       n_rst,
   input  logic       start,
   input  logic       decrypt,
   input  logic       abort,
   output logic       busy,
   output logic       load_block,
   output logic [4:0] round_count,
   output logic [1:0] key_count,
   output logic       cnt_rollover,
   output logic       key_rollover,
   output logic       reverse,
   output logic       round_en,
   output logic       done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [4:0] LAST_ROUND = 5'(NUM_ROUNDS);
   localparam logic [1:0] LAST_PASS  = 2'(NUM_PASSES - 1);

   state_t     state_reg, state_next;
   logic [4:0] round_reg, round_next;
   logic [1:0] key_reg, key_next;
   logic       mode_reg, mode_next;

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_reg <= IDLE;
         round_reg <= 5'd0;
         key_reg   <= 2'd0;
         mode_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         round_reg <= round_next;
         key_reg   <= key_next;
         mode_reg  <= mode_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      round_next   = round_reg;
      key_next     = key_reg;
      mode_next    = mode_reg;
      load_block   = 1'b0;
      cnt_rollover = 1'b0;
      key_rollover = 1'b0;
      busy         = (state_reg == RUN);
      done         = (state_reg == DONE);
      round_en     = (state_reg == RUN) && (round_reg != 5'd0);
      // Pass 1 runs the schedule opposite to the block mode (EDE / DED).
      reverse      = (state_reg == RUN) && (mode_reg ^ (key_reg == 2'd1));
      round_count  = round_reg;
      key_count    = key_reg;

      case (state_reg)
         IDLE: begin
            round_next = 5'd0;
            key_next   = 2'd0;
            if (start) begin
               load_block = n_rst;
               state_next = RUN;
               mode_next  = decrypt;
            end
         end
         RUN: begin
            if (abort) begin
               // key_rollover makes the key generator reload key0.
               key_rollover = 1'b1;
               state_next   = IDLE;
               round_next   = 5'd0;
               key_next     = 2'd0;
            end else if (round_reg == LAST_ROUND) begin
               cnt_rollover = 1'b1;
               round_next   = 5'd0;
               if (key_reg == LAST_PASS) begin
                  key_rollover = 1'b1;
                  key_next     = 2'd0;
                  state_next   = DONE;
               end else begin
                  key_next = key_reg + 2'd1;
               end
            end else begin
               round_next = round_reg + 5'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_des_round_sequencer.sv
// Bench for des_round_sequencer: block-position reference model checked every
// cycle, directed blocks with hand-computed cycle expectations, random phase.
module tb_des_round_sequencer;

   localparam int NR = 16;
   localparam int NP = 3;
   localparam int PL = NR + 1;
   localparam int L  = NP * PL;

   logic       clk = 1'b0;
   logic       n_rst = 1'b0;
   logic       start = 1'b0;
   logic       decrypt = 1'b0;
   logic       abort = 1'b0;
   logic       busy, load_block, cnt_rollover, key_rollover, reverse, round_en, done;
   logic [4:0] round_count;
   logic [1:0] key_count;

   int n_checks = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   des_round_sequencer #(.NUM_ROUNDS(NR), .NUM_PASSES(NP)) dut (
      .clk(clk), .n_rst(n_rst), .start(start), .decrypt(decrypt), .abort(abort),
      .busy(busy), .load_block(load_block), .round_count(round_count),
      .key_count(key_count), .cnt_rollover(cnt_rollover), .key_rollover(key_rollover),
      .reverse(reverse), .round_en(round_en), .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", name, act, exp);
   endtask

   // Reference: position within the block (0 idle, 1..L run, L+1 done).
   int m_pos = 0;
   bit m_mode = 1'b0;
   always @(negedge clk) begin
      int rc, kc;
      bit run;
      logic [13:0] exp_v, act_v;
      run = (m_pos >= 1) && (m_pos <= L);
      rc  = run ? (m_pos - 1) % PL : 0;
      kc  = run ? (m_pos - 1) / PL : 0;
      exp_v = {run, (m_pos == 0) && start && n_rst, 5'(rc), 2'(kc),
               run && (rc == NR) && !abort,
               run && (abort || (rc == NR && kc == NP - 1)),
               run && (m_mode ^ (kc == 1)),
               run && (rc != 0),
               m_pos == L + 1};
      act_v = {busy, load_block, round_count, key_count, cnt_rollover,
               key_rollover, reverse, round_en, done};
      if (chk_en) begin
         n_checks++;
         if (act_v === exp_v) n_pass++;
         else $display("FAIL model_cycle pos=%0d: got %h, required %h", m_pos, act_v, exp_v);
      end
      if (!n_rst) begin
         m_pos  = 0;
         m_mode = 1'b0;
      end else if (m_pos == 0) begin
         if (start) begin
            m_pos  = 1;
            m_mode = decrypt;
         end
      end else if (m_pos <= L) begin
         m_pos = abort ? 0 : m_pos + 1;
      end else begin
         m_pos = 0;
      end
   end

   task automatic wait_idle();
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (!busy && !done) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("wait_idle_timeout", 0, 1);
   endtask

   // Hand-computed cycle expectations for one block accepted from IDLE.
   task automatic run_block(input bit dec, input int abort_at, input bit hold);
      int ren;
      int dn;
      ren = 0;
      dn  = 0;
      @(posedge clk); #1;
      start = 1'b1; decrypt = dec; abort = 1'b0;
      @(negedge clk);
      check("load_block_accept", load_block, 1);
      for (int c = 1; c <= 53; c++) begin
         @(posedge clk); #1;
         start   = hold;
         decrypt = 1'($urandom_range(0, 1));
         abort   = (c == abort_at);
         @(negedge clk);
         if (round_en) ren++;
         if (done) dn++;
         if (abort_at == 0) begin
            case (c)
               1:  begin check("c1_busy", busy, 1); check("c1_rev", reverse, dec); check("c1_rc", round_count, 0); end
               17: begin check("c17_cnt_roll", cnt_rollover, 1); check("c17_key_roll", key_rollover, 0); end
               18: begin check("c18_rev", reverse, !dec); check("c18_kc", key_count, 1); end
               34: check("c34_cnt_roll", cnt_rollover, 1);
               35: begin check("c35_rev", reverse, dec); check("c35_kc", key_count, 2); end
               51: begin check("c51_cnt_roll", cnt_rollover, 1); check("c51_key_roll", key_rollover, 1); end
               52: begin check("c52_done", done, 1); check("c52_busy", busy, 0); end
               53: begin check("c53_done", done, 0); check("c53_load", load_block, hold); end
               default: ;
            endcase
         end else if (c == abort_at) begin
            check("abort_rc", round_count, (abort_at - 1) % PL);
            check("abort_kc", key_count, (abort_at - 1) / PL);
            check("abort_key_roll", key_rollover, 1);
            check("abort_cnt_roll", cnt_rollover, 0);
         end else if (c == abort_at + 1) begin
            check("post_abort_busy", busy, 0);
            check("post_abort_rc", round_count, 0);
         end
      end
      if (abort_at == 0) check("round_en_cycles", ren, 48);
      else check("abort_no_done", dn, 0);
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
   endtask

   initial begin
      n_rst = 1'b0; start = 1'b1;
      @(posedge clk); #1;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_load_block", load_block, 0);
      check("rst_rc", round_count, 0);
      check("rst_done", done, 0);
      @(posedge clk); #1;
      start = 1'b0; n_rst = 1'b1;

      run_block(1'b0, 0, 1'b0);
      wait_idle();
      run_block(1'b1, 0, 1'b0);
      wait_idle();
      run_block(1'b0, 25, 1'b0);
      wait_idle();
      run_block(1'b1, 0, 1'b0);
      wait_idle();
      run_block(1'b1, 51, 1'b0);
      wait_idle();
      run_block(1'b0, 0, 1'b1);
      wait_idle();

      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         start   = ($urandom_range(0, 3) == 0);
         decrypt = 1'($urandom_range(0, 1));
         abort   = ($urandom_range(0, 79) == 0);
         n_rst   = ($urandom_range(0, 599) != 0);
      end
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0; n_rst = 1'b1;
      wait_idle();
      repeat (2) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
